// File: rtl/mem_pkg.sv
// Shared packet-buffer memory types: block geometry, footer layout and the
// round-robin one-hot picker used by the SRAM port arbiter and egress scheduler.
package mem_pkg;

    localparam int ADDR_W           = 12;
    localparam int BLOCK_BITS       = 64;
    localparam int RD_PORTS_DEFAULT = 4;
    localparam int RD_PORTS_MAX     = 8;
    localparam int PTR_W            = 3;

    // Footer lives in the low bits of each block: next block index, then eop.
    localparam int FTR_NEXT_LSB = 0;
    localparam int FTR_EOP_BIT  = ADDR_W;

    typedef logic [RD_PORTS_MAX-1:0] rd_sel_t;

    // First set bit at or above ptr, wrapping at RD_PORTS_MAX. Requesters
    // narrower than RD_PORTS_MAX leave the top bits zero, so the wrap point is
    // effectively the real requester count.
    function automatic rd_sel_t rr_pick(input rd_sel_t req, input logic [PTR_W-1:0] ptr);
        rd_sel_t          gnt;
        logic [PTR_W-1:0] idx;
        gnt = '0;
        for (int i = RD_PORTS_MAX - 1; i >= 0; i--) begin
            idx = ptr + PTR_W'(i);
            if (req[idx]) begin
                gnt      = '0;
                gnt[idx] = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot picker with its own rotating pointer; combinational grant.
// The pointer moves past the winner only when the caller asserts advance.
module rr_arbiter
    import mem_pkg::*;
#(
    parameter int N = RD_PORTS_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] ptr_nxt;
    rd_sel_t       pick;

    assign pick = rr_pick(rd_sel_t'(req), PTR_W'(ptr));
    assign gnt  = pick[N-1:0];

    if (N < RD_PORTS_MAX) begin : g_hi
        logic unused_hi;
        assign unused_hi = |pick[RD_PORTS_MAX-1:N];
    end

    always_comb begin
        ptr_nxt = ptr;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) ptr_nxt = (i == N - 1) ? '0 : PW'(i + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       ptr <= '0;
        else if (advance) ptr <= ptr_nxt;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port packet-buffer SRAM arbiter: one writer (priority) vs NUM_RD round-robin readers.
// Grant is combinational; read data returns one cycle after the grant, no return backpressure.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_RD        = RD_PORTS_DEFAULT,
    parameter int RD_STARVE_MAX = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_req_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [BLOCK_BITS-1:0]    wr_data_i,
    output logic                     wr_gnt_o,
    input  logic [NUM_RD-1:0]        rd_req_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]        rd_gnt_o,
    output logic [NUM_RD-1:0]        rd_rvalid_o,
    output logic [BLOCK_BITS-1:0]    rd_rdata_o,
    output logic                     mem_we_o,
    output logic                     mem_re_o,
    output logic [ADDR_W-1:0]        mem_addr_o,
    output logic [BLOCK_BITS-1:0]    mem_wdata_o,
    input  logic [BLOCK_BITS-1:0]    mem_rdata_i
);

    localparam logic [3:0] STARVE_LIM = 4'(RD_STARVE_MAX);

    logic              rd_pending;
    logic              wr_win;
    logic              rd_win;
    logic [3:0]        starve_cnt;
    logic [NUM_RD-1:0] arb_gnt;

    assign rd_pending = |rd_req_i;
    assign wr_win     = wr_req_i && (!rd_pending || (starve_cnt < STARVE_LIM));
    assign rd_win     = rd_pending && !wr_win;

    rr_arbiter #(.N(NUM_RD)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (rd_req_i),
        .advance (rd_win),
        .gnt     (arb_gnt)
    );

    assign wr_gnt_o    = wr_win;
    assign rd_gnt_o    = rd_win ? arb_gnt : '0;
    assign mem_we_o    = wr_win;
    assign mem_re_o    = |rd_gnt_o;
    assign mem_wdata_o = wr_win ? wr_data_i : '0;
    assign rd_rdata_o  = mem_rdata_i;

    always_comb begin
        mem_addr_o = '0;
        if (wr_win) begin
            mem_addr_o = wr_addr_i;
        end else begin
            for (int r = 0; r < NUM_RD; r++) begin
                if (rd_gnt_o[r]) mem_addr_o = rd_addr_i[r*ADDR_W +: ADDR_W];
            end
        end
    end

    // Counts writes that bypassed waiting readers; reaching the limit forces a read slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (rd_win || !rd_pending) begin
            starve_cnt <= '0;
        end else if (wr_win && (starve_cnt < STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_rvalid_o <= '0;
        else        rd_rvalid_o <= rd_gnt_o;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural single-port SRAM behind it.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int NRD = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   wr_req;
    logic [ADDR_W-1:0]      wr_addr;
    logic [BLOCK_BITS-1:0]  wr_data;
    logic                   wr_gnt;
    logic [NRD-1:0]         rd_req;
    logic [NRD*ADDR_W-1:0]  rd_addr;
    logic [NRD-1:0]         rd_gnt;
    logic [NRD-1:0]         rd_rvalid;
    logic [BLOCK_BITS-1:0]  rd_rdata;
    logic                   mem_we;
    logic                   mem_re;
    logic [ADDR_W-1:0]      mem_addr;
    logic [BLOCK_BITS-1:0]  mem_wdata;
    logic [BLOCK_BITS-1:0]  mem_rdata;

    logic [BLOCK_BITS-1:0]  sram [0:(1<<ADDR_W)-1];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.NUM_RD(NRD), .RD_STARVE_MAX(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_req_i    (wr_req),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .wr_gnt_o    (wr_gnt),
        .rd_req_i    (rd_req),
        .rd_addr_i   (rd_addr),
        .rd_gnt_o    (rd_gnt),
        .rd_rvalid_o (rd_rvalid),
        .rd_rdata_o  (rd_rdata),
        .mem_we_o    (mem_we),
        .mem_re_o    (mem_re),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= sram[mem_addr];
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] blk(input int i, input int nxt, input logic eop);
        return {32'hB10C_0000 + 32'(i), 19'd0, eop, 12'(nxt)};
    endfunction

    task automatic set_rd_addr(input int r, input int a);
        rd_addr[r*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    int          chain [10] = '{37, 905, 128, 2047, 319, 4093, 777, 2560, 1234, 3001};
    logic [3:0]  rr_exp [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic        wr_seq [10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    initial begin
        int cur;
        int pulses;
        for (int a = 0; a < (1 << ADDR_W); a++) sram[a] = '0;
        mem_rdata = '0;
        rst_n = 1'b0; wr_req = 1'b0; wr_addr = '0; wr_data = '0;
        rd_req = '0; rd_addr = '0;
        #3;
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_re", 64'(mem_re), 64'd0);
        chk("rst_rvalid", 64'(rd_rvalid), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();

        // Chain write, then follow it from block 37 as reader 0.
        for (int i = 0; i < 10; i++) begin
            wr_req  = 1'b1;
            wr_addr = ADDR_W'(chain[i]);
            wr_data = blk(i, (i < 9) ? chain[i+1] : 0, i == 9);
            #1;
            chk("chain_wr_gnt", 64'(wr_gnt), 64'd1);
            cyc();
        end
        wr_req = 1'b0;
        cur = 37;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            rd_req = 4'b0001;
            set_rd_addr(0, cur);
            #1;
            chk("chain_gnt", 64'(rd_gnt), 64'd1);
            chk("chain_addr", 64'(mem_addr), 64'(chain[i]));
            cyc();
            rd_req = '0;
            chk("chain_rvalid", 64'(rd_rvalid), 64'd1);
            if (rd_rvalid[0]) pulses++;
            chk("chain_next", 64'(rd_rdata[ADDR_W-1:0]), 64'((i < 9) ? chain[i+1] : 0));
            chk("chain_eop", 64'(rd_rdata[FTR_EOP_BIT]), 64'(i == 9));
            cur = int'(rd_rdata[ADDR_W-1:0]);
        end
        chk("chain_pulses", 64'(pulses), 64'd10);
        cyc();
        chk("chain_quiet", 64'(rd_rvalid), 64'd0);

        // Round-robin across four continuously requesting readers.
        do_reset();
        for (int r = 0; r < NRD; r++) set_rd_addr(r, 10 * (r + 1));
        rd_req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_gnt", 64'(rd_gnt), 64'(rr_exp[k]));
            chk("rr_we", 64'(mem_we), 64'd0);
            chk("rr_rvalid", 64'(rd_rvalid), (k == 0) ? 64'd0 : 64'(rr_exp[k-1]));
            cyc();
        end
        rd_req = '0;
        #1;
        chk("rr_rvalid_last", 64'(rd_rvalid), 64'b1000);
        cyc();

        // Write pressure against reader 2: four writes, one read, repeat.
        do_reset();
        wr_req = 1'b1; wr_addr = 12'd100; wr_data = 64'hDEAD_BEEF;
        rd_req = 4'b0100; set_rd_addr(2, 200);
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("starve_wr", 64'(wr_gnt), 64'(wr_seq[k]));
            chk("starve_rd", 64'(rd_gnt), wr_seq[k] ? 64'd0 : 64'b0100);
            chk("starve_addr", 64'(mem_addr), wr_seq[k] ? 64'd100 : 64'd200);
            chk("starve_excl", 64'(mem_we & mem_re), 64'd0);
            cyc();
        end
        wr_req = 1'b0; rd_req = '0;
        cyc();

        // Same-address write and read presented together.
        do_reset();
        wr_req = 1'b1; wr_addr = 12'h0AB; wr_data = 64'h55;
        rd_req = 4'b0010; set_rd_addr(1, 12'h0AB);
        #1;
        chk("haz_wr_first", 64'(wr_gnt), 64'd1);
        chk("haz_rd_wait", 64'(rd_gnt), 64'd0);
        cyc();
        wr_req = 1'b0;
        #1;
        chk("haz_rd_gnt", 64'(rd_gnt), 64'b0010);
        cyc();
        rd_req = '0;
        chk("haz_rvalid", 64'(rd_rvalid), 64'b0010);
        chk("haz_rdata", rd_rdata, 64'h55);

        // Reset lands in the cycle reader 3 is granted; pointer was at 2.
        do_reset();
        rd_req = 4'b0010; set_rd_addr(1, 11); set_rd_addr(3, 33);
        #1;
        chk("mid_pre_gnt", 64'(rd_gnt), 64'b0010);
        cyc();
        rd_req = 4'b1000;
        #1;
        chk("mid_gnt3", 64'(rd_gnt), 64'b1000);
        rst_n = 1'b0;
        rd_req = '0;
        #1;
        chk("mid_rvalid_now", 64'(rd_rvalid), 64'd0);
        cyc();
        chk("mid_rvalid", 64'(rd_rvalid), 64'd0);
        chk("mid_mem", {mem_wdata[31:0], 16'(mem_addr), 14'd0, mem_we, mem_re}, 64'd0);
        rst_n = 1'b1;
        cyc();
        rd_req = 4'b1111;
        #1;
        chk("mid_ptr0", 64'(rd_gnt), 64'b0001);
        rd_req = '0;
        cyc();
        cyc();

        // Idle: nothing requested for twenty cycles.
        for (int k = 0; k < 20; k++) begin
            chk("idle", {44'd0, 16'(mem_addr), rd_rvalid} | {62'd0, mem_we, mem_re}, 64'd0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single-port packet-buffer SRAM between one block-write requester and NUM_RD block-read requesters, such as `memory_read_ctrl` instances serving egress ports. Each cycle it grants at most one requester and drives the SRAM `we`/`re`/`addr`/`wdata` from that requester. It routes the read data, which arrives one cycle later, back to the reader that issued the read. Writes have priority, and a bounded starvation counter guarantees read progress; readers are served round-robin.

## Interface
- NUM_RD, default 4: number of read requesters, range 2..8.
- RD_STARVE_MAX, default 4: consecutive write grants allowed while any read is pending, range 1..15.
- ADDR_W and BLOCK_BITS come from `mem_pkg` and are not parameters of this block.

Ports:
- clk  in  1  system clock; all state on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- wr_req_i  in  1  write request; held until granted.
- wr_addr_i  in  ADDR_W  block index to write.
- wr_data_i  in  BLOCK_BITS  block contents, including the footer.
- wr_gnt_o  out  1  write performed this cycle; combinational.
- rd_req_i  in  NUM_RD  per-reader read request; held until granted.
- rd_addr_i  in  NUM_RD×ADDR_W  per-reader block index, packed as reader r at [r*ADDR_W +: ADDR_W].
- rd_gnt_o  out  NUM_RD  one-hot read grant; combinational.
- rd_rvalid_o  out  NUM_RD  one-hot return valid, registered.
- rd_rdata_o  out  BLOCK_BITS  returned block; broadcast, equal to mem_rdata_i.
- mem_we_o  out  1  SRAM write enable.
- mem_re_o  out  1  SRAM read enable.
- mem_addr_o  out  ADDR_W  SRAM address.
- mem_wdata_o  out  BLOCK_BITS  SRAM write data.
- mem_rdata_i  in  BLOCK_BITS  SRAM read data, valid the cycle after mem_re_o.

## Operation
- Grant decision per cycle, evaluated combinationally from the requests and registered state:
  - If wr_req_i=1 and (no read is pending, or starve_cnt < RD_STARVE_MAX): grant the write.
  - Otherwise, if any rd_req_i bit is set: grant the first set bit searching from rr_ptr upward, modulo NUM_RD.
  - Otherwise: idle, and all mem enables are 0.
- mem_we_o = wr_gnt_o. mem_re_o = |rd_gnt_o. mem_wdata_o = wr_data_i whenever a write is granted, else 0. mem_addr_o is the granted requester's address, else 0.
- mem_we_o and mem_re_o are never 1 in the same cycle.
- starve_cnt, 4 bits:
  - Increments on a write grant while any rd_req_i bit is set.
  - Clears on any read grant, or on any cycle with no read pending.
  - Saturates at RD_STARVE_MAX.
- rr_ptr: on a read grant to reader k, rr_ptr <= (k+1) mod NUM_RD. Unchanged otherwise.
- Return path: rd_rvalid_o <= rd_gnt_o, registered. rd_rdata_o is meaningful only where a rd_rvalid_o bit is 1.
- A requester may drop its request only after being granted. Changing the address while requesting and not yet granted is illegal; the arbiter does not check for it.
- The block holds no data and has no backpressure on the return path; readers must accept rd_rvalid_o unconditionally.

## Timing
- Reset: all outputs 0; rr_ptr=0; starve_cnt=0; rd_rvalid_o=0.
- Reset asserted mid-operation: any rd_rvalid_o pending for the next cycle is dropped, and the affected reader must re-request.
- Grant latency: 0 cycles, combinational request-to-grant.
- Read latency: rd_rvalid_o bit k is 1 exactly 1 cycle after rd_gnt_o[k]=1, with rd_rdata_o = mem_rdata_i.
- Throughput:
  - One SRAM access per cycle.
  - A reader requesting continuously alone is granted every cycle.
  - Under continuous write pressure, readers get at least 1 grant per RD_STARVE_MAX+1 cycles.
- Write and read to the same address arriving together: the write goes first unless starved out; a read in the following cycle returns the new data.
- Back-to-back grants to different readers yield back-to-back rd_rvalid_o with no bubble.

## Structure
- Add to `mem_pkg`:
  - `RD_PORTS_DEFAULT` = 4.
  - `rd_sel_t`, a one-hot vector type.
  - Function `rr_pick(req, ptr)`, returning a one-hot result.
- Sub-module `rr_arbiter`: parameter N; inputs req and advance; outputs one-hot gnt; owns rr_ptr. It is reusable for the egress scheduler.
- Top level holds the write-priority and starvation logic, the SRAM mux, and the return register.

## Test plan
1. **Single reader chain:** write 10 linked blocks (37→905→128→2047→319→4093→777→2560→1234→3001, last with eop=1), then connect one `memory_read_ctrl` as reader 0 starting at 37. Required: 10 rd_rvalid_o[0] pulses, each footer next_idx matching the chain, and eop only on the block at 3001.
2. **Round-robin:** readers 0..3 request continuously with no writes. Required: grants cycle 0,1,2,3,0,…, and rd_rvalid_o follows each grant 1 cycle later.
3. **Write priority with starvation:** with RD_STARVE_MAX=4, wr_req_i is held high and reader 2 requests. Required: 4 write grants, then rd_gnt_o[2] for 1 cycle, then writes resume.
4. **Same-address hazard:** write block 0x0AB with data 0x55 while reader 1 requests 0x0AB in the same cycle. Required: write granted first, then the read returns 0x55.
5. **Reset mid-read:** assert rst_n=0 in the cycle rd_gnt_o[3]=1. Required: rd_rvalid_o stays 0, all mem outputs are 0, and rr_ptr=0 after release.
6. **Idle:** no requests for 20 cycles. Required: mem_we_o=mem_re_o=0, mem_addr_o=0, and no rd_rvalid_o pulses.
